// File: rtl/fp_add_arb_pkg.sv
// Common constants and types for the fp_add arbiter slice.
`include "fp_defs.vh"

package fp_add_arb_pkg;
    localparam int FP_LATENCY = `FP_ADD_LATENCY;
    localparam int STAT_W     = `FP_ARB_STAT_W;

    typedef logic [STAT_W-1:0] stat_t;
endpackage

// File: rtl/fp_add.sv
// Five-stage floating-point adder without special-case handling.
// Denormal inputs and results are flushed to zero; round to nearest even.
module fp_add #(
    parameter int DATA_W = 32,
    parameter int EXP_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] res,
    output logic              done
);
    localparam int MAN_W = DATA_W - 1 - EXP_W;
    localparam int MW    = MAN_W + 1;
    localparam int XW    = MW + 3;
    localparam int SW    = XW + 1;
    localparam int LZ_W  = $clog2(XW + 1);

    logic [4:0]        vld;
    logic              swap;
    logic [DATA_W-1:0] big, sml;
    logic [EXP_W-1:0]  e_big, e_sml;

    logic              s1_sign, s1_sub;
    logic [EXP_W-1:0]  s1_exp, s1_diff;
    logic [MW-1:0]     s1_mbig, s1_msml;

    logic              s2_sign, s2_sub;
    logic [EXP_W-1:0]  s2_exp;
    logic [XW-1:0]     s2_mbig, s2_msml;

    logic              s3_sign;
    logic [EXP_W-1:0]  s3_exp;
    logic [SW-1:0]     s3_sum;

    logic              s4_sign, s4_zero;
    logic [EXP_W:0]    s4_exp;
    logic [XW-1:0]     s4_norm;

    logic [2*MW+1:0]   sh;
    logic [XW-1:0]     aln;
    logic [LZ_W-1:0]   lz;
    logic              found;
    logic [XW-1:0]     norm;
    logic [EXP_W:0]    norm_exp;
    logic              norm_zero;

    logic              rnd;
    logic [MW:0]       mant;
    logic [EXP_W:0]    exp_r;
    logic [MAN_W-1:0]  frac;
    logic [DATA_W-1:0] pack;

    assign swap  = a[DATA_W-2:0] < b[DATA_W-2:0];
    assign big   = swap ? b : a;
    assign sml   = swap ? a : b;
    assign e_big = big[DATA_W-2 -: EXP_W];
    assign e_sml = sml[DATA_W-2 -: EXP_W];

    // Alignment keeps guard and round bits; everything below collapses into sticky.
    assign sh = {s1_msml, {(MW+2){1'b0}}} >> s1_diff;

    always_comb begin
        if (s1_diff >= EXP_W'(XW))
            aln = {{(MW+2){1'b0}}, |s1_msml};
        else
            aln = {sh[2*MW+1:MW], |sh[MW-1:0]};
    end

    always_comb begin
        lz        = '0;
        found     = 1'b0;
        for (int i = XW - 1; i >= 0; i--) begin
            if (!found && s3_sum[i]) begin
                lz    = LZ_W'(XW - 1 - i);
                found = 1'b1;
            end
        end
        norm      = s3_sum[XW-1:0] << lz;
        norm_exp  = {1'b0, s3_exp} - (EXP_W+1)'(lz);
        norm_zero = 1'b0;
        if (s3_sum[SW-1]) begin
            norm     = {s3_sum[SW-1:2], s3_sum[1] | s3_sum[0]};
            norm_exp = {1'b0, s3_exp} + (EXP_W+1)'(1);
        end else if (!found || ({1'b0, s3_exp} <= (EXP_W+1)'(lz))) begin
            norm_zero = 1'b1;
        end
    end

    always_comb begin
        rnd   = s4_norm[2] & (s4_norm[1] | s4_norm[0] | s4_norm[3]);
        mant  = {1'b0, s4_norm[XW-1:3]} + (MW+1)'(rnd);
        exp_r = s4_exp + (EXP_W+1)'(mant[MW]);
        frac  = mant[MW] ? mant[MW-1:1] : mant[MAN_W-1:0];
        if (s4_zero)
            pack = '0;
        else if (exp_r >= {1'b0, {EXP_W{1'b1}}})
            pack = {s4_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        else
            pack = {s4_sign, exp_r[EXP_W-1:0], frac};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld     <= '0;
            s1_sign <= 1'b0;
            s1_sub  <= 1'b0;
            s1_exp  <= '0;
            s1_diff <= '0;
            s1_mbig <= '0;
            s1_msml <= '0;
            s2_sign <= 1'b0;
            s2_sub  <= 1'b0;
            s2_exp  <= '0;
            s2_mbig <= '0;
            s2_msml <= '0;
            s3_sign <= 1'b0;
            s3_exp  <= '0;
            s3_sum  <= '0;
            s4_sign <= 1'b0;
            s4_zero <= 1'b0;
            s4_exp  <= '0;
            s4_norm <= '0;
            res     <= '0;
        end else begin
            vld     <= {vld[3:0], start};
            s1_sign <= big[DATA_W-1];
            s1_sub  <= big[DATA_W-1] ^ sml[DATA_W-1];
            s1_exp  <= e_big;
            s1_diff <= e_big - e_sml;
            s1_mbig <= {|e_big, big[MAN_W-1:0]};
            s1_msml <= {|e_sml, sml[MAN_W-1:0]};
            s2_sign <= s1_sign;
            s2_sub  <= s1_sub;
            s2_exp  <= s1_exp;
            s2_mbig <= {s1_mbig, 3'b000};
            s2_msml <= aln;
            s3_sign <= s2_sign;
            s3_exp  <= s2_exp;
            s3_sum  <= s2_sub ? ({1'b0, s2_mbig} - {1'b0, s2_msml})
                              : ({1'b0, s2_mbig} + {1'b0, s2_msml});
            s4_sign <= s3_sign;
            s4_zero <= norm_zero;
            s4_exp  <= norm_exp;
            s4_norm <= norm;
            res     <= pack;
        end
    end

    assign done = vld[4];
endmodule

// File: rtl/fp_add_arb_rr_arbiter.sv
// Combinational round-robin picker: first requester after ptr wins, wrapping to 0.
module rr_arbiter #(
    parameter int NREQ  = 4,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_vld,
    output logic [IDX_W-1:0] next_ptr
);
    int j;

    always_comb begin
        grant     = '0;
        grant_idx = ptr;
        grant_vld = 1'b0;
        j         = 0;
        for (int k = 1; k <= NREQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NREQ)
                j = j - NREQ;
            if (!grant_vld && req[j]) begin
                grant_vld = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = IDX_W'(j);
            end
        end
        next_ptr = grant_idx;
    end
endmodule

// File: rtl/fp_defs.vh
// Shared fp_add build constants: fixed pipeline latency and arbiter statistics width.
`ifndef FP_DEFS_VH
`define FP_DEFS_VH
`define FP_ADD_LATENCY 5
`define FP_ARB_STAT_W  16
`endif

// File: rtl/fp_add_arb.sv
// Round-robin sharing of one fp_add among NREQ requesters, one op in flight each.
// Optional FP_ARB_STATS_EN adds per-requester issue and stall counters.
module fp_add_arb
    import fp_add_arb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int DATA_W  = 32,
    parameter int EXP_W   = 8,
    parameter int LATENCY = FP_LATENCY
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*DATA_W-1:0] req_op_a,
    input  logic [NREQ*DATA_W-1:0] req_op_b,
    output logic [NREQ-1:0]        rsp_valid,
    input  logic [NREQ-1:0]        rsp_ready,
    output logic [NREQ*DATA_W-1:0] rsp_res,
    output logic [NREQ-1:0]        busy
`ifdef FP_ARB_STATS_EN
    ,
    output logic [NREQ*STAT_W-1:0] stat_issue,
    output logic [NREQ*STAT_W-1:0] stat_stall
`endif
);
    localparam int IDX_W = $clog2(NREQ);

    logic [IDX_W-1:0]  rr_ptr, next_ptr, grant_idx;
    logic [NREQ-1:0]   elig, grant;
    logic              grant_vld, run_q, issue;
    logic [DATA_W-1:0] add_a, add_b, add_res;
    logic              add_rst, add_done;
    logic [LATENCY-1:0] tag_vld;
    logic [IDX_W-1:0]  tag_idx [LATENCY];
    logic              done_hit;
    logic [IDX_W-1:0]  done_idx;

    assign elig = req_valid & ~busy;

    rr_arbiter #(.NREQ(NREQ), .IDX_W(IDX_W)) u_rr (
        .req       (elig),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_vld (grant_vld),
        .next_ptr  (next_ptr)
    );

    // run_q holds off grants while reset is asserted and for the release cycle.
    assign issue     = grant_vld & run_q;
    assign req_ready = grant & {NREQ{run_q}};
    assign add_a     = req_op_a[int'(grant_idx)*DATA_W +: DATA_W];
    assign add_b     = req_op_b[int'(grant_idx)*DATA_W +: DATA_W];
    assign add_rst   = ~rst_n;

    fp_add #(.DATA_W(DATA_W), .EXP_W(EXP_W)) u_add (
        .clk   (clk),
        .rst   (add_rst),
        .start (issue),
        .a     (add_a),
        .b     (add_b),
        .res   (add_res),
        .done  (add_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q  <= 1'b0;
            rr_ptr <= IDX_W'(NREQ - 1);
        end else begin
            run_q <= 1'b1;
            if (issue)
                rr_ptr <= next_ptr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_vld <= '0;
            for (int s = 0; s < LATENCY; s++)
                tag_idx[s] <= '0;
        end else begin
            tag_vld    <= {tag_vld[LATENCY-2:0], issue};
            tag_idx[0] <= grant_idx;
            for (int s = 1; s < LATENCY; s++)
                tag_idx[s] <= tag_idx[s-1];
        end
    end

    assign done_hit = add_done & tag_vld[LATENCY-1];
    assign done_idx = tag_idx[LATENCY-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= '0;
            rsp_res   <= '0;
            busy      <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (done_hit && done_idx == IDX_W'(i)) begin
                    rsp_valid[i]                   <= 1'b1;
                    rsp_res[i*DATA_W +: DATA_W]    <= add_res;
                end else if (rsp_valid[i] && rsp_ready[i]) begin
                    rsp_valid[i] <= 1'b0;
                end
                if (issue && grant[i])
                    busy[i] <= 1'b1;
                else if (rsp_valid[i] && rsp_ready[i])
                    busy[i] <= 1'b0;
            end
        end
    end

`ifdef FP_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_issue <= '0;
            stat_stall <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && req_ready[i])
                    stat_issue[i*STAT_W +: STAT_W] <= stat_issue[i*STAT_W +: STAT_W] + stat_t'(1);
                if (req_valid[i] && !req_ready[i])
                    stat_stall[i*STAT_W +: STAT_W] <= stat_stall[i*STAT_W +: STAT_W] + stat_t'(1);
            end
        end
    end
`endif
endmodule

// File: tb/tb_fp_add_arb.sv
// Directed bench for fp_add_arb: issue timing, rotation, hold, reset drop, wrap, stats.
module tb_fp_add_arb;
    localparam int NREQ = 4;
    localparam int DW   = 32;

    logic clk = 1'b0;
    logic rst_n;
    logic [NREQ-1:0]    req_valid, req_ready, rsp_valid, rsp_ready, busy;
    logic [NREQ*DW-1:0] req_op_a, req_op_b, rsp_res;
`ifdef FP_ARB_STATS_EN
    logic [NREQ*16-1:0] stat_issue, stat_stall;
`endif

    logic [31:0] a_v [4];
    logic [31:0] b_v [4];
    logic [31:0] s_v [4];
    int n_chk = 0;
    int n_bad = 0;
    int hs_cnt = 0;
    int st_cnt = 0;
    int others = 0;

    always #5 clk = ~clk;

    fp_add_arb u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op_a   (req_op_a),
        .req_op_b   (req_op_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_res    (rsp_res),
        .busy       (busy)
`ifdef FP_ARB_STATS_EN
        ,
        .stat_issue (stat_issue),
        .stat_stall (stat_stall)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // All four valid from cycle 0: rotation 0..3, then idle until req0 is free at +7.
    function automatic logic [3:0] exp_grant(input int c);
        if (c < 0 || c >= 98 || (c % 7) >= 4)
            return 4'b0000;
        return 4'b0001 << (c % 7);
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        a_v = '{32'h3F800000, 32'h40400000, 32'h3F000000, 32'h40A00000};
        b_v = '{32'h40000000, 32'h40800000, 32'h3E800000, 32'hC0400000};
        s_v = '{32'h40400000, 32'h40E00000, 32'h3F400000, 32'h40000000};
        rst_n = 1'b0;
        req_valid = '0;
        rsp_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_op_a[i*DW +: DW] = a_v[i];
            req_op_b[i*DW +: DW] = b_v[i];
        end

        // reset state, with a request present
        repeat (2) @(posedge clk);
        #1;
        req_valid = 4'b0001;
        #1;
        chk("rst_ready", req_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rspv", rsp_valid, 0);
        chk("rst_res_lo", rsp_res[63:0], 0);
        chk("rst_res_hi", rsp_res[127:64], 0);
        req_valid = '0;
        rst_n = 1'b1;
        step();
        step();

        // T1: 1.0 + 2.0 on req0
        req_valid = 4'b0001;
        #1;
        chk("t1_ready", req_ready, 4'b0001);
        step();
        req_valid = '0;
        for (int k = 1; k < 6; k++) begin
            #1;
            chk("t1_early_rsp", rsp_valid, 0);
            chk("t1_busy", busy, 4'b0001);
            step();
        end
        #1;
        chk("t1_rspv", rsp_valid, 4'b0001);
        chk("t1_res", rsp_res[31:0], 32'h40400000);
        rsp_ready = 4'b0001;
        step();
        rsp_ready = '0;
        #1;
        chk("t1_consumed", rsp_valid, 0);
        chk("t1_idle", busy, 0);

        // T4: reset two cycles after an issue on req1
        step();
        req_valid = 4'b0010;
        #1;
        chk("t4_issue", req_ready, 4'b0010);
        step();
        req_valid = '0;
        step();
        rst_n = 1'b0;
        req_valid = 4'b0100;
        #1;
        chk("t4_rst_ready", req_ready, 0);
        chk("t4_rst_busy", busy, 0);
        chk("t4_rst_rspv", rsp_valid, 0);
        step();
        step();
        req_valid = '0;
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("t4_dropped", rsp_valid, 0);
            chk("t4_busy", busy, 0);
            step();
        end

        // T2: all valid, results consumed at once
        rsp_ready = 4'b1111;
        for (int c = 0; c < 105; c++) begin
            req_valid = (c < 98) ? 4'b1111 : 4'b0000;
            #1;
            chk("t2_grant", req_ready, exp_grant(c));
            chk("t2_rspv", rsp_valid, exp_grant(c - 6));
            for (int i = 0; i < NREQ; i++)
                if (rsp_valid[i])
                    chk("t2_res", rsp_res[i*DW +: DW], s_v[i]);
            hs_cnt += $countones(req_valid & req_ready);
            st_cnt += $countones(req_valid & ~req_ready);
            step();
        end
`ifdef FP_ARB_STATS_EN
        begin
            int si, ss;
            si = 0;
            ss = 0;
            for (int i = 0; i < NREQ; i++) begin
                si += int'(stat_issue[i*16 +: 16]);
                ss += int'(stat_stall[i*16 +: 16]);
            end
            chk("t6_issue_obs", si, hs_cnt);
            chk("t6_stall_obs", ss, st_cnt);
            chk("t6_issue_abs", si, 56);
            chk("t6_stall_abs", ss, 336);
        end
`endif

        // T5: req2 alone; second grant wraps past 3,0,1 and leaves the pointer on 2
        req_valid = 4'b0100;
        #1;
        chk("t5_first", req_ready, 4'b0100);
        step();
        req_valid = '0;
        repeat (5) step();
        #1;
        chk("t5_rspv", rsp_valid, 4'b0100);
        chk("t5_res", rsp_res[2*DW +: DW], 32'h3F400000);
        step();
        req_valid = 4'b0100;
        #1;
        chk("t5_wrap", req_ready, 4'b0100);
        step();
        req_valid = 4'b1010;
        #1;
        chk("t5_ptr_hold", req_ready, 4'b1000);
        step();
        req_valid = '0;
        repeat (8) step();

        // T3: req1 result held unconsumed while req0/req3 keep issuing
        req_op_a[DW +: DW] = 32'h3FC00000;
        req_op_b[DW +: DW] = 32'h40200000;
        rsp_ready = 4'b1101;
        for (int k = 0; k < 27; k++) begin
            req_valid = (k == 0) ? 4'b0010 : 4'b1011;
            #1;
            if (k == 0) begin
                chk("t3_issue", req_ready, 4'b0010);
            end else begin
                chk("t3_ready1", req_ready[1], 0);
                chk("t3_busy1", busy[1], 1);
                if (k >= 6) begin
                    chk("t3_rspv1", rsp_valid[1], 1);
                    chk("t3_res1", rsp_res[DW +: DW], 32'h40800000);
                end
            end
            others += $countones(req_ready & 4'b1001);
            step();
        end
        chk("t3_others", others, 8);
        rsp_ready = 4'b1111;
        req_valid = 4'b0010;
        step();
        #1;
        chk("t3_released", busy[1], 0);
        chk("t3_regrant", req_ready, 4'b0010);
        step();
        req_valid = '0;
        repeat (8) step();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
